// File: rtl/instruction_fetch.sv
// Single-cycle instruction fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Optional J/JAL predecode in fetch is enabled by defining FETCH_JUMP_PREDECODE_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PC_plus4,
    output logic        IFID_valid
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    // Natural 32-bit wrap gives the modulo-2^32 increment.
    assign pc_plus4 = pc + 32'd4;
    assign Address  = pc;

`ifdef FETCH_JUMP_PREDECODE_EN
    logic        is_jump;
    logic [31:0] jump_target;

    // Opcodes 0x02 (J) and 0x03 (JAL) differ only in bit 26.
    assign is_jump     = (Instruction[31:27] == 5'b00001);
    assign jump_target = {pc_plus4[31:28], Instruction[25:0], 2'b00};
`endif

    always_comb begin
        next_pc = pc_plus4;
        if (redirect_valid)
            next_pc = {redirect_target[31:2], 2'b00};
        else if (stall)
            next_pc = pc;
`ifdef FETCH_JUMP_PREDECODE_EN
        else if (is_jump)
            next_pc = jump_target;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc <= {RESET_PC[31:2], 2'b00};
        else
            pc <= next_pc;
    end

    // A redirect squashes the word fetched down the wrong path, so it bubbles like a flush.
    always_ff @(posedge clk) begin
        if (reset || flush || redirect_valid) begin
            IFID_Instruction <= 32'h0;
            IFID_PC_plus4    <= 32'h0;
            IFID_valid       <= 1'b0;
        end else if (!stall) begin
            IFID_Instruction <= Instruction;
            IFID_PC_plus4    <= pc_plus4;
            IFID_valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed vector bench for instruction_fetch; expectations follow the build's
// FETCH_JUMP_PREDECODE_EN setting for the J/JAL rows.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect_valid;
    logic [31:0] redirect_target, Instruction;
    logic [31:0] Address, IFID_Instruction, IFID_PC_plus4;
    logic        IFID_valid;

    int tests = 0;
    int fails = 0;

    instruction_fetch #(.RESET_PC(32'h00000000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .Address(Address), .Instruction(Instruction),
        .IFID_Instruction(IFID_Instruction), .IFID_PC_plus4(IFID_PC_plus4),
        .IFID_valid(IFID_valid)
    );

    always #5 clk = ~clk;

`ifdef FETCH_JUMP_PREDECODE_EN
    localparam logic [31:0] JAL_NEXT = 32'h00000010;
    localparam logic [31:0] J_NEXT   = 32'h00000040;
`else
    localparam logic [31:0] JAL_NEXT = 32'h0000000C;
    localparam logic [31:0] J_NEXT   = 32'h00000104;
`endif

    typedef struct {
        logic        rst, stl, fls, rv;
        logic [31:0] rt, ins;
        logic [31:0] e_addr, e_ins, e_pc4;
        logic        e_v;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(logic rst, logic stl, logic fls, logic rv, logic [31:0] rt,
                                logic [31:0] ins, logic [31:0] ea, logic [31:0] ei,
                                logic [31:0] ep, logic ev);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fls = fls; v.rv = rv; v.rt = rt; v.ins = ins;
        v.e_addr = ea; v.e_ins = ei; v.e_pc4 = ep; v.e_v = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic stl, input logic fls, input logic rv,
                        input logic [31:0] rt, input logic [31:0] ins);
        reset = rst; stall = stl; flush = fls; redirect_valid = rv;
        redirect_target = rt; Instruction = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ea, input logic [31:0] ei,
                           input logic [31:0] ep, input logic ev);
        chk({tag, ".Address"}, Address, ea);
        chk({tag, ".IFID_Instruction"}, IFID_Instruction, ei);
        chk({tag, ".IFID_PC_plus4"}, IFID_PC_plus4, ep);
        chk({tag, ".IFID_valid"}, {31'b0, IFID_valid}, {31'b0, ev});
    endtask

    initial begin
        //               rst stl fls rv  target        instr          Address       IFID_Instr     PC+4          v
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0); // reset
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,        32'h20040005, 32'h4,        32'h20040005, 32'h4,        1);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,        32'h11111111, 32'h8,        32'h11111111, 32'h8,        1);
        vecs[3]  = mk(0, 1, 0, 0, 32'h0,        32'h22222222, 32'h8,        32'h11111111, 32'h8,        1); // stall
        vecs[4]  = mk(0, 1, 0, 0, 32'h0,        32'h22222222, 32'h8,        32'h11111111, 32'h8,        1);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,        32'h22222222, 32'hC,        32'h22222222, 32'hC,        1);
        vecs[6]  = mk(0, 0, 1, 0, 32'h0,        32'h33333333, 32'h10,       32'h0,        32'h0,        0); // flush
        vecs[7]  = mk(0, 1, 1, 0, 32'h0,        32'h44444444, 32'h10,       32'h0,        32'h0,        0); // flush+stall
        vecs[8]  = mk(0, 1, 0, 0, 32'h0,        32'h44444444, 32'h10,       32'h0,        32'h0,        0); // stalled bubble
        vecs[9]  = mk(0, 0, 0, 0, 32'h0,        32'h44444444, 32'h14,       32'h44444444, 32'h14,       1);
        vecs[10] = mk(0, 1, 0, 1, 32'h13,       32'h55555555, 32'h10,       32'h0,        32'h0,        0); // redirect+stall
        vecs[11] = mk(0, 0, 0, 0, 32'h0,        32'h55555555, 32'h14,       32'h55555555, 32'h14,       1);
        vecs[12] = mk(0, 0, 0, 1, 32'h8,        32'h0,        32'h8,        32'h0,        32'h0,        0);
        vecs[13] = mk(0, 0, 0, 0, 32'h0,        32'h0C000004, JAL_NEXT,     32'h0C000004, 32'hC,        1); // jal
        vecs[14] = mk(0, 0, 0, 1, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFC, 32'h0,        32'h0,        0); // wrap
        vecs[15] = mk(0, 0, 0, 0, 32'h0,        32'h66666666, 32'h0,        32'h66666666, 32'h0,        1);
        vecs[16] = mk(0, 1, 0, 0, 32'h0,        32'h77777777, 32'h0,        32'h66666666, 32'h0,        1);
        vecs[17] = mk(1, 1, 1, 1, 32'h40,       32'h77777777, 32'h0,        32'h0,        32'h0,        0); // reset wins
        vecs[18] = mk(0, 0, 0, 0, 32'h0,        32'h77777777, 32'h4,        32'h77777777, 32'h4,        1);
        vecs[19] = mk(0, 0, 0, 1, 32'h101,      32'h88888888, 32'h100,      32'h0,        32'h0,        0);
        vecs[20] = mk(0, 0, 0, 0, 32'h0,        32'h08000010, J_NEXT,       32'h08000010, 32'h104,      1); // j

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].stl, vecs[i].fls, vecs[i].rv, vecs[i].rt, vecs[i].ins);
            chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_ins, vecs[i].e_pc4, vecs[i].e_v);
        end

        // Long stall with the memory word changing underneath: IF/ID and PC must not move.
        step(0, 0, 0, 1, 32'h200, 32'h0);
        chk_all("seq.redir", 32'h200, 32'h0, 32'h0, 1'b0);
        step(0, 0, 0, 0, 32'h0, 32'hAAAA0001);
        chk_all("seq.fetch", 32'h204, 32'hAAAA0001, 32'h204, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0, 32'h0, 32'hC0DE0000 + k);
            chk_all($sformatf("seq.stall%0d", k), 32'h204, 32'hAAAA0001, 32'h204, 1'b1);
        end
        step(0, 0, 0, 0, 32'h0, 32'hBBBB0002);
        chk_all("seq.release", 32'h208, 32'hBBBB0002, 32'h208, 1'b1);

        // Reset in the middle of a stall drops the held word and restarts at RESET_PC.
        step(0, 1, 0, 0, 32'h0, 32'h12345678);
        step(1, 1, 0, 0, 32'h0, 32'h12345678);
        chk_all("seq.rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
        step(0, 0, 0, 0, 32'h0, 32'h9999AAAA);
        chk_all("seq.rst_resume", 32'h4, 32'h9999AAAA, 32'h4, 1'b1);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        chk("seq.rst_seq8", Address, 32'h8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
